// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the DSC stream decoder.
package dsc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dsc_dec_state_t;

   // Counter width needed to integrate the product of two DATA_WIDTH operands.
   function automatic int DSC_CNT_W(input int dw);
      return 2 * dw + 1;
   endfunction

endpackage

// File: rtl/dsc_ones_counter.sv
// Clearable up-counter for the cycle and ones tallies; one-cycle update.
// Backpressure: none, advances only when inc is high, clr takes priority.
module dsc_ones_counter #(
   parameter int CNT_WIDTH = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dsc_stream_decoder.sv
// Integrates a stochastic bitstream over window_len qualified cycles into a ones count.
// Result lands window_len cycles after start; en low stalls the window one cycle per cycle.
module dsc_stream_decoder
   import dsc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = DSC_CNT_W(DATA_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 en,
   input  logic                 sn_in,
   input  logic [CNT_WIDTH-1:0] window_len,
   output logic [CNT_WIDTH-1:0] bin_data_out,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 op_finished,
   output logic                 busy
);

   dsc_dec_state_t       state_q, state_d;
   logic [CNT_WIDTH-1:0] len_q, len_d;
   logic                 op_finished_q;
   logic                 busy_q;

   logic                 cnt_clr;
   logic                 cyc_inc;
   logic                 ones_inc;
   logic [CNT_WIDTH-1:0] cyc_cnt;
   logic [CNT_WIDTH-1:0] ones_cnt;
   logic [CNT_WIDTH-1:0] cyc_next;

   assign cyc_next = cyc_cnt + CNT_WIDTH'(1);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_clr  = 1'b0;
      cyc_inc  = 1'b0;
      ones_inc = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && abort) begin
               state_d = IDLE;
            end else if (start) begin
               len_d   = window_len;
               cnt_clr = 1'b1;
               state_d = (window_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Abort freezes the partial counts; start is not looked at here.
            if (abort) begin
               state_d = IDLE;
            end else if (en) begin
               cyc_inc  = 1'b1;
               ones_inc = sn_in;
               if (cyc_next == len_q) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         len_q         <= '0;
         op_finished_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         op_finished_q <= (state_d == DONE);
         busy_q        <= (state_d == RUN);
      end
   end

   dsc_ones_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cyc_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cyc_inc),
      .cnt   (cyc_cnt)
   );

   dsc_ones_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ones_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (ones_inc),
      .cnt   (ones_cnt)
   );

   assign bin_data_out = ones_cnt;
   assign cycle_count  = cyc_cnt;
   assign op_finished  = op_finished_q;
   assign busy         = busy_q;

endmodule
